// File: rtl/fetch_decode.sv
// Fetch/decode sequencer: fetches 16-bit instruction words over a req/ack port
// and presents decoded datapath controls for one EXEC cycle per instruction.
package fetch_decode_pkg;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT,
    ALU_SHL, ALU_SHR, ALU_ROL, ALU_ROR, ALU_INC, ALU_DEC
  } AluCmd;

  typedef struct packed {
    logic dst_in_sel;  // 1 = immediate, 0 = ALU result
  } CtrlSig;
endpackage

module fetch_decode
  import fetch_decode_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic            reg_wr_en,
  output logic [11:0]     operands,
  output AluCmd           alu_cmd,
  output CtrlSig          ctrl_sig,
  output logic            halted
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam int JW = (PC_W < 8) ? PC_W : 8;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            imem_req_q, imem_req_d;
  logic            reg_wr_en_q, reg_wr_en_d;
  logic            halted_q, halted_d;
  logic [3:0]      op_q, op_d;

  assign op_q = ir_q[15:12];
  assign op_d = ir_d[15:12];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = RESET_PC;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          4'hE:    pc_d = PC_W'(ir_q[JW-1:0]);
          4'hF:    state_d = S_HALT;
          default: pc_d = pc_q + 1'b1;
        endcase
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake/status outputs are registered from the next-state view.
    imem_req_d  = (state_d == S_FETCH);
    halted_d    = (state_d == S_HALT);
    reg_wr_en_d = (state_d == S_EXEC) && (op_d >= 4'h1) && (op_d <= 4'hD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= 16'h0000;
      imem_req_q  <= 1'b0;
      reg_wr_en_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      imem_req_q  <= imem_req_d;
      reg_wr_en_q <= reg_wr_en_d;
      halted_q    <= halted_d;
    end
  end

  // Decoded fields follow IR, so they persist through the next FETCH.
  always_comb begin
    alu_cmd             = AluCmd'(4'd0);
    ctrl_sig.dst_in_sel = (op_q == 4'h1);
    if (op_q >= 4'h2 && op_q <= 4'hD) alu_cmd = AluCmd'(op_q - 4'd2);
  end

  assign operands  = ir_q[11:0];
  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign reg_wr_en = reg_wr_en_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Instruction-level reference model drives a randomized imem responder and
// checks every cycle of each fetch/exec pair against the decode rules.
module tb_fetch_decode;
  import fetch_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, imem_ack;
  logic [15:0] imem_rdata;
  logic        imem_req, reg_wr_en, halted;
  logic [7:0]  imem_addr;
  logic [11:0] operands;
  AluCmd       alu_cmd;
  CtrlSig      ctrl_sig;

  int          vectors = 0, miscompares = 0;
  logic [15:0] mem [256];
  logic [7:0]  pc;

  always #5 clk = ~clk;

  fetch_decode #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .reg_wr_en(reg_wr_en), .operands(operands),
    .alu_cmd(alu_cmd), .ctrl_sig(ctrl_sig), .halted(halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (pc %0h)", tag, got, exp, pc);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req"},    imem_req, 0);
    chk({tag, ".addr"},   imem_addr, 0);
    chk({tag, ".wr"},     reg_wr_en, 0);
    chk({tag, ".opnd"},   operands, 0);
    chk({tag, ".alu"},    alu_cmd, 0);
    chk({tag, ".sel"},    ctrl_sig.dst_in_sel, 0);
    chk({tag, ".halted"}, halted, 0);
  endtask

  // One instruction: called at a negedge with the DUT expected in FETCH at pc.
  task automatic do_instr(input int delay);
    logic [15:0] instr;
    logic [3:0]  op;
    int          exp_alu;
    chk("fetch.req", imem_req, 1);
    chk("fetch.addr", imem_addr, pc);
    chk("fetch.halted", halted, 0);
    for (int i = 0; i < delay; i++) begin
      start = 1'($urandom_range(0, 1));
      step;
      start = 1'b0;
      chk("wait.req", imem_req, 1);
      chk("wait.addr", imem_addr, pc);
      chk("wait.wr", reg_wr_en, 0);
    end
    instr      = mem[pc];
    op         = instr[15:12];
    imem_ack   = 1'b1;
    imem_rdata = instr;
    step;
    imem_ack   = 1'($urandom_range(0, 1));
    imem_rdata = 16'($urandom);
    start      = 1'($urandom_range(0, 1));
    exp_alu    = (op >= 2 && op <= 13) ? int'(op) - 2 : 0;
    chk("exec.wr", reg_wr_en, (op >= 1 && op <= 13) ? 1 : 0);
    chk("exec.opnd", operands, instr[11:0]);
    chk("exec.alu", alu_cmd, exp_alu);
    chk("exec.sel", ctrl_sig.dst_in_sel, (op == 1) ? 1 : 0);
    chk("exec.req", imem_req, 0);
    if (op == 4'hE)      pc = instr[7:0];
    else if (op != 4'hF) pc = pc + 8'd1;
    step;
    imem_ack = 1'b0;
    start    = 1'b0;
    chk("post.wr", reg_wr_en, 0);
    chk("post.opnd", operands, instr[11:0]);
    chk("post.alu", alu_cmd, exp_alu);
    if (op == 4'hF) begin
      chk("halt.halted", halted, 1);
      chk("halt.req", imem_req, 0);
      repeat ($urandom_range(1, 4)) begin
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = 16'($urandom);
        step;
        imem_ack = 1'b0;
        chk("halt.hold", halted, 1);
        chk("halt.req", imem_req, 0);
        chk("halt.wr", reg_wr_en, 0);
      end
      start = 1'b1;
      step;
      start = 1'b0;
      pc    = 8'h00;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0;
    pc  = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1305; mem[1] = 16'h2312; mem[2] = 16'hD312; mem[3] = 16'hE0FE;
    step; step;
    chk_reset("reset");
    rst = 1'b0;
    step;
    chk_reset("idle");
    start = 1'b1;
    step;
    start = 1'b0;

    // LDI, ALU with long ack stall, ALU, JMP, two NOPs wrapping back to 0.
    do_instr(0);
    do_instr(5);
    do_instr(1);
    do_instr(0);
    do_instr(2);
    do_instr(0);
    chk("wrap.addr", imem_addr, 8'h00);
    chk("wrap.req", imem_req, 1);

    // Reset in FETCH with a simultaneous ack: the word must be dropped.
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'h1305;
    step;
    rst = 1'b0; imem_ack = 1'b0;
    chk_reset("rstfetch");
    step;
    chk_reset("rstidle");

    mem[0] = 16'hF000;
    pc     = 8'h00;
    start  = 1'b1;
    step;
    start  = 1'b0;
    do_instr(0);

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 300; n++) do_instr($urandom_range(0, 3));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
